// File: rtl/consmax_cfg_sched_if.sv
// Bus between upstream traffic/config master and the ConSmax config scheduler.
// Carries softmax element valids, config write requests and array-side outputs.
interface consmax_cfg_sched_if #(
  parameter int NUM_HEAD  = 4,
  parameter int LUT_ADDR  = 4,
  parameter int LUT_DATA  = 16,
  parameter int CDATA_BIT = 8
);
  logic                 cfg_valid;
  logic                 cfg_ready;
  logic                 cfg_sel;
  logic [LUT_ADDR:0]    cfg_addr;
  logic [LUT_DATA-1:0]  cfg_data;
  logic [NUM_HEAD-1:0]  in_valid;
  logic                 in_ready;
  logic [NUM_HEAD-1:0]  out_valid;
  logic                 lut_wen;
  logic [LUT_ADDR:0]    lut_waddr;
  logic [LUT_DATA-1:0]  lut_wdata;
  logic [CDATA_BIT-1:0] cfg_consmax_shift;
  logic [15:0]          perf_stall_cnt;

  modport master (
    output cfg_valid, cfg_sel, cfg_addr, cfg_data, in_valid,
    input  cfg_ready, in_ready, out_valid, lut_wen, lut_waddr,
    input  lut_wdata, cfg_consmax_shift, perf_stall_cnt
  );

  modport slave (
    input  cfg_valid, cfg_sel, cfg_addr, cfg_data, in_valid,
    output cfg_ready, in_ready, out_valid, lut_wen, lut_waddr,
    output lut_wdata, cfg_consmax_shift, perf_stall_cnt
  );
endinterface

// File: rtl/consmax_cfg_sched.sv
// ConSmax runtime config scheduler: drains traffic, applies LUT/shift writes, resumes.
// Optional stall counter enabled by defining CONSMAX_CTRL_PERF_EN.
module consmax_cfg_sched #(
  parameter int NUM_HEAD  = 4,
  parameter int LUT_ADDR  = 4,
  parameter int LUT_DATA  = 16,
  parameter int CDATA_BIT = 8,
  parameter int DRAIN_CYC = 2,
  parameter int MAX_BURST = 8,
  parameter int SHIFT_RST = 0
) (
  input logic clk,
  input logic rstn,
  consmax_cfg_sched_if.slave bus
);

  localparam int IW = $clog2(DRAIN_CYC + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    PASS  = 2'd0,
    DRAIN = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t               r_state;
  logic [IW-1:0]        r_idle_cnt;
  logic [BW-1:0]        r_burst_cnt;
  logic                 r_hold;
  logic                 r_lut_wen;
  logic [LUT_ADDR:0]    r_lut_waddr;
  logic [LUT_DATA-1:0]  r_lut_wdata;
  logic [CDATA_BIT-1:0] r_shift;

  logic w_in_ready;
  logic w_ov_any;
  logic w_drained;
  logic w_last;

  assign w_in_ready = (r_state == PASS);
  assign w_ov_any   = |bus.out_valid;
  assign w_drained  = (r_idle_cnt >= IW'(DRAIN_CYC - 1));
  assign w_last     = (r_burst_cnt == BW'(MAX_BURST - 1));

  assign bus.in_ready  = w_in_ready;
  assign bus.cfg_ready = (r_state == WRITE);
  assign bus.out_valid = bus.in_valid & {NUM_HEAD{w_in_ready}};

  assign bus.lut_wen           = r_lut_wen;
  assign bus.lut_waddr         = r_lut_waddr;
  assign bus.lut_wdata         = r_lut_wdata;
  assign bus.cfg_consmax_shift = r_shift;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= PASS;
      r_idle_cnt  <= IW'(DRAIN_CYC);
      r_burst_cnt <= '0;
      r_hold      <= 1'b0;
      r_lut_wen   <= 1'b0;
      r_lut_waddr <= '0;
      r_lut_wdata <= '0;
      r_shift     <= CDATA_BIT'(SHIFT_RST);
    end else begin
      r_lut_wen <= 1'b0;
      if (w_ov_any)
        r_idle_cnt <= '0;
      else if (r_idle_cnt < IW'(DRAIN_CYC))
        r_idle_cnt <= r_idle_cnt + 1'b1;
      unique case (r_state)
        PASS: begin
          r_hold <= 1'b0;
          if (bus.cfg_valid && !r_hold)
            r_state <= DRAIN;
        end
        DRAIN: begin
          if (w_drained)
            r_state <= WRITE;
        end
        WRITE: begin
          if (!bus.cfg_valid) begin
            r_state     <= PASS;
            r_burst_cnt <= '0;
            r_hold      <= 1'b1;
          end else begin
            if (bus.cfg_sel) begin
              r_shift <= bus.cfg_data[CDATA_BIT-1:0];
            end else begin
              r_lut_wen   <= 1'b1;
              r_lut_waddr <= bus.cfg_addr;
              r_lut_wdata <= bus.cfg_data;
            end
            // burst cap keeps traffic from starving under continuous config
            if (w_last) begin
              r_state     <= PASS;
              r_burst_cnt <= '0;
              r_hold      <= 1'b1;
            end else begin
              r_burst_cnt <= r_burst_cnt + 1'b1;
            end
          end
        end
        default: r_state <= PASS;
      endcase
    end
  end

`ifdef CONSMAX_CTRL_PERF_EN
  logic [15:0] r_perf_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_perf_cnt <= '0;
    else if ((|bus.in_valid) && !w_in_ready && (r_perf_cnt != 16'hFFFF))
      r_perf_cnt <= r_perf_cnt + 16'd1;
  end

  assign bus.perf_stall_cnt = r_perf_cnt;
`else
  assign bus.perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_consmax_cfg_sched.sv
// Directed bench for consmax_cfg_sched: table-driven traffic/shift timeline
// plus hand sequences for bursts, reset mid-burst, stall counter and starvation.
module tb_consmax_cfg_sched;
  localparam int NH = 4;
  localparam int LA = 4;
  localparam int LD = 16;
  localparam int CB = 8;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  consmax_cfg_sched_if #(
    .NUM_HEAD(NH), .LUT_ADDR(LA), .LUT_DATA(LD), .CDATA_BIT(CB)
  ) bus ();

  consmax_cfg_sched #(
    .NUM_HEAD(NH), .LUT_ADDR(LA), .LUT_DATA(LD), .CDATA_BIT(CB),
    .DRAIN_CYC(2), .MAX_BURST(8), .SHIFT_RST(0)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
  );

  typedef struct {
    logic [3:0]  iv;
    logic        cv;
    logic        cs;
    logic [15:0] cd;
    logic [3:0]  ov;
    logic        ir;
    logic        cr;
    logic [7:0]  sh;
  } vec_t;

  vec_t vt[14];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] iv, input logic cv,
                       input logic cs, input logic [4:0] ca,
                       input logic [15:0] cd);
    bus.in_valid  = iv;
    bus.cfg_valid = cv;
    bus.cfg_sel   = cs;
    bus.cfg_addr  = ca;
    bus.cfg_data  = cd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rstn = 1'b0;
    drive(4'h0, 1'b0, 1'b0, 5'h0, 16'h0);
    repeat (2) @(posedge clk);
    #3;
    rstn = 1'b1;
  endtask

  function automatic logic acc();
    return bus.cfg_valid && bus.cfg_ready;
  endfunction

  initial begin
    int idx, nw, run, runs, gap, first_rdy, k;
    int sh_cyc, wen_cyc, traf, bursts, acc_run;
    logic prev_ov, prev_rdy, resumed, seen;

    // reset state
    do_reset;
    #1;
    chk("rst_wen", bus.lut_wen, 0);
    chk("rst_waddr", bus.lut_waddr, 0);
    chk("rst_wdata", bus.lut_wdata, 0);
    chk("rst_shift", bus.cfg_consmax_shift, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_cfg_ready", bus.cfg_ready, 0);
    chk("rst_perf", bus.perf_stall_cnt, 0);

    // traffic then shift write: table of per-cycle vectors
    for (int i = 0; i < 8; i++)
      vt[i] = '{4'hF, 1'b0, 1'b0, 16'h0, 4'hF, 1'b1, 1'b0, 8'h00};
    vt[8]  = '{4'hF, 1'b1, 1'b1, 16'h3, 4'hF, 1'b1, 1'b0, 8'h00};
    vt[9]  = '{4'hF, 1'b1, 1'b1, 16'h3, 4'h0, 1'b0, 1'b0, 8'h00};
    vt[10] = '{4'hF, 1'b1, 1'b1, 16'h3, 4'h0, 1'b0, 1'b0, 8'h00};
    vt[11] = '{4'h0, 1'b1, 1'b1, 16'h3, 4'h0, 1'b0, 1'b1, 8'h00};
    vt[12] = '{4'h0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b0, 1'b1, 8'h03};
    vt[13] = '{4'h0, 1'b0, 1'b0, 16'h0, 4'h0, 1'b1, 1'b0, 8'h03};
    for (int c = 0; c < 14; c++) begin
      tick;
      drive(vt[c].iv, vt[c].cv, vt[c].cs, 5'h0, vt[c].cd);
      #1;
      chk($sformatf("t2_ov_c%0d", c), bus.out_valid, vt[c].ov);
      chk($sformatf("t2_ir_c%0d", c), bus.in_ready, vt[c].ir);
      chk($sformatf("t2_cr_c%0d", c), bus.cfg_ready, vt[c].cr);
      chk($sformatf("t2_sh_c%0d", c), bus.cfg_consmax_shift, vt[c].sh);
      chk($sformatf("t2_wen_c%0d", c), bus.lut_wen, 0);
    end

    // 32 LUT writes on an idle array
    do_reset;
    idx = 0; nw = 0; run = 0; runs = 0; gap = 0;
    first_rdy = -1; prev_rdy = 1'b0;
    for (int c = 0; c < 120; c++) begin
      tick;
      if (c >= 5 && idx < 32)
        drive(4'h0, 1'b1, 1'b0, 5'(idx), 16'h3F80 + 16'(idx));
      else
        drive(4'h0, 1'b0, 1'b0, 5'h0, 16'h0);
      #1;
      if (bus.lut_wen) begin
        chk("t1_addr", bus.lut_waddr, nw);
        chk("t1_data", bus.lut_wdata, 16'h3F80 + 16'(nw));
        nw++; run++;
      end else if (run > 0) begin
        chk("t1_run_len", run, 8);
        runs++; run = 0;
      end
      if (bus.in_ready) gap++;
      if (bus.cfg_ready && !prev_rdy) begin
        if (first_rdy < 0) first_rdy = c;
        else chk("t1_pass_gap", gap >= 1, 1);
        gap = 0;
      end
      prev_rdy = bus.cfg_ready;
      if (acc()) idx++;
    end
    chk("t1_first_ready", first_rdy, 7);
    chk("t1_total", nw, 32);
    chk("t1_runs", runs, 4);

    // shift then LUT write in one burst with traffic pending
    do_reset;
    k = 0; sh_cyc = -1; wen_cyc = -1; prev_ov = 1'b0; resumed = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick;
      if (c >= 2 && k == 0)
        drive(4'hF, 1'b1, 1'b1, 5'h0, 16'h005A);
      else if (c >= 2 && k == 1)
        drive(4'hF, 1'b1, 1'b0, 5'h11, 16'hABCD);
      else
        drive(4'hF, 1'b0, 1'b0, 5'h0, 16'h0);
      #1;
      if (!bus.in_ready) chk("t3_ov_blocked", bus.out_valid, 0);
      if (bus.lut_wen) begin
        chk("t3_safe", prev_ov, 0);
        chk("t3_waddr", bus.lut_waddr, 5'h11);
        chk("t3_wdata", bus.lut_wdata, 16'hABCD);
        if (wen_cyc < 0) wen_cyc = c;
      end
      if (sh_cyc < 0 && bus.cfg_consmax_shift == 8'h5A) sh_cyc = c;
      if (k == 2 && bus.in_ready && bus.out_valid == 4'hF) resumed = 1'b1;
      prev_ov = |bus.out_valid;
      if (acc()) k++;
    end
    chk("t3_shift_cyc", sh_cyc, 6);
    chk("t3_wen_after_shift", wen_cyc - sh_cyc, 1);
    chk("t3_resumed", resumed, 1);

    // reset asserted in WRITE with a request pending
    do_reset;
    k = 0; seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick;
      if (k == 0) drive(4'h0, 1'b1, 1'b1, 5'h0, 16'h0077);
      else drive(4'h0, 1'b1, 1'b0, 5'(k), 16'h1000 + 16'(k));
      #1;
      if (bus.lut_wen) seen = 1'b1;
      else if (acc()) k++;
    end
    chk("t4_reached_write", seen && bus.cfg_ready, 1);
    chk("t4_shift_before", bus.cfg_consmax_shift, 8'h77);
    rstn = 1'b0;
    drive(4'h0, 1'b1, 1'b0, 5'h9, 16'h1009);
    #1;
    chk("t4_rst_wen", bus.lut_wen, 0);
    chk("t4_rst_in_ready", bus.in_ready, 1);
    chk("t4_rst_cfg_ready", bus.cfg_ready, 0);
    chk("t4_rst_shift", bus.cfg_consmax_shift, 0);
    @(posedge clk);
    #3;
    rstn = 1'b1;
    tick;
    #1;
    chk("t4_redrain_ir", bus.in_ready, 0);
    chk("t4_redrain_cr", bus.cfg_ready, 0);
    chk("t4_redrain_wen", bus.lut_wen, 0);
    tick;
    #1;
    chk("t4_accept_cr", bus.cfg_ready, 1);
    tick;
    drive(4'h0, 1'b0, 1'b0, 5'h0, 16'h0);
    #1;
    chk("t4_wen", bus.lut_wen, 1);
    chk("t4_waddr", bus.lut_waddr, 5'h9);

    // stall counter over a 2-write burst with traffic held
    do_reset;
    k = 0;
    for (int c = 0; c < 14; c++) begin
      tick;
      drive(4'hF, k < 2, 1'b0, 5'(k + 20), 16'h2000);
      #1;
      if (acc()) k++;
    end
    chk("t5_writes", k, 2);
`ifdef CONSMAX_CTRL_PERF_EN
    chk("t5_perf", bus.perf_stall_cnt, 5);
`else
    chk("t5_perf", bus.perf_stall_cnt, 0);
`endif

    // continuous traffic and config
    do_reset;
    k = 0; traf = 0; bursts = 0; acc_run = 0; prev_rdy = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick;
      drive(4'hF, 1'b1, 1'b0, 5'(k), 16'(k));
      #1;
      if (|bus.out_valid) traf++;
      if (bus.cfg_ready && !prev_rdy) begin
        if (bursts > 0) chk("t6_traffic_gap", traf >= 1, 1);
        traf = 0;
      end
      if (!bus.cfg_ready && prev_rdy) begin
        chk("t6_burst_len", acc_run, 8);
        bursts++; acc_run = 0;
      end
      prev_rdy = bus.cfg_ready;
      if (acc()) begin
        acc_run++; k++;
      end
    end
    chk("t6_bursts", bursts >= 5, 1);

    drive(4'h0, 1'b0, 1'b0, 5'h0, 16'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
